// File: rtl/fir_pkg.sv
// Shared types for the FIR sequencer: state encoding and default tap width.
package fir_pkg;

    localparam int W_WSP_DEF = 6;
    localparam int W_PROBKI  = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        MAC,
        STORE,
        NEXT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/fir_sterowanie.sv
// Sequencer for a time-multiplexed FIR: walks every tap once per output sample
// and steers the external sample counter, coefficient address and MAC.
module fir_sterowanie
    import fir_pkg::*;
#(
    parameter int W_WSP = W_WSP_DEF
) (
    input  logic                clk_b,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [W_PROBKI-1:0] ile_probek,
    input  logic [W_WSP-1:0]    ile_wsp,
    input  logic                licznik_full,
    output logic                FSM_zapisz_probki,
    output logic                FSM_reset_licznik,
    output logic                FSM_nowa_probka,
    output logic [W_WSP-1:0]    A_wsp_FIR,
    output logic                mac_clear,
    output logic                mac_en,
    output logic                zapisz_wynik,
    output logic                done,
    output logic                blad,
    output logic                busy
);

    state_t              state;
    state_t              nxt;
    logic [W_PROBKI-1:0] probki_q;
    logic [W_WSP-1:0]    wsp_q;
    logic [W_WSP-1:0]    wsp_last;
    logic [W_WSP-1:0]    a_nxt;
    logic                blad_nxt;
    logic                latch;

    assign wsp_last = wsp_q - W_WSP'(1);

    always_comb begin
        nxt      = state;
        blad_nxt = blad;
        latch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    latch    = 1'b1;
                    blad_nxt = 1'b0;
                    nxt      = LOAD;
                end
            end
            LOAD: begin
                if (probki_q == '0 || wsp_q == '0) begin
                    blad_nxt = 1'b1;
                    nxt      = DONE;
                end else begin
                    nxt = CLR;
                end
            end
            CLR:   nxt = MAC;
            MAC:   nxt = (A_wsp_FIR == wsp_last) ? STORE : MAC;
            STORE: nxt = NEXT;
            NEXT:  nxt = CHECK;
            CHECK: nxt = licznik_full ? DONE : CLR;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (stop && state != IDLE) begin
            nxt = IDLE;
        end
    end

    // Address only advances while staying in MAC, so it never passes wsp_last.
    always_comb begin
        a_nxt = '0;
        if (nxt == MAC && state == MAC) begin
            a_nxt = A_wsp_FIR + W_WSP'(1);
        end
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            state             <= IDLE;
            probki_q          <= '0;
            wsp_q             <= '0;
            A_wsp_FIR         <= '0;
            blad              <= 1'b0;
            FSM_zapisz_probki <= 1'b0;
            FSM_reset_licznik <= 1'b0;
            FSM_nowa_probka   <= 1'b0;
            mac_clear         <= 1'b0;
            mac_en            <= 1'b0;
            zapisz_wynik      <= 1'b0;
            done              <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state     <= nxt;
            A_wsp_FIR <= a_nxt;
            blad      <= blad_nxt;
            if (latch) begin
                probki_q <= ile_probek;
                wsp_q    <= ile_wsp;
            end
            // Strobes decoded from the next state so they align with it.
            FSM_zapisz_probki <= (nxt == LOAD);
            FSM_reset_licznik <= (nxt == LOAD);
            mac_clear         <= (nxt == CLR);
            mac_en            <= (nxt == MAC);
            zapisz_wynik      <= (nxt == STORE);
            FSM_nowa_probka   <= (nxt == NEXT);
            done              <= (nxt == DONE);
            busy              <= (nxt != IDLE);
        end
    end

endmodule

// File: doc/fir_sterowanie.md
FIR_STEROWANIE -- requirements
Module: fir_sterowanie

Interface
REQ-001 SHALL have parameter W_WSP, default 6, giving the tap-index width (max 2^W_WSP-1 taps).
REQ-002 SHALL have port clk_b, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin filtering a block.
REQ-005 SHALL have port stop, input, 1, abort request.
REQ-006 SHALL have port ile_probek, input, 14, sample count, sampled at start.
REQ-007 SHALL have port ile_wsp, input, W_WSP, tap count, sampled at start.
REQ-008 SHALL have port licznik_full, input, 1, sample-counter end flag.
REQ-009 SHALL have ports FSM_zapisz_probki, FSM_reset_licznik and FSM_nowa_probka, each output, 1, the sample-counter controls.
REQ-010 SHALL have port A_wsp_FIR, output, W_WSP, coefficient/tap address.
REQ-011 SHALL have ports mac_clear and mac_en, each output, 1: clear accumulator; accumulate the current tap.
REQ-012 SHALL have ports zapisz_wynik, done and blad, each output, 1: store the result; block finished (pulse); parameter error (level).
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, LOAD, CLR, MAC, STORE, NEXT, CHECK and DONE.
REQ-015 In IDLE, start=1 SHALL latch ile_probek/ile_wsp, clear blad, and go to LOAD.
REQ-016 In LOAD, the block SHALL assert FSM_zapisz_probki and FSM_reset_licznik for exactly 1 cycle.
  - If either latched count is 0: set blad=1 and go to DONE.
  - Otherwise: go to CLR.
REQ-017 In CLR, the block SHALL assert mac_clear for 1 cycle, set A_wsp_FIR=0, and go to MAC.
REQ-018 In MAC, mac_en SHALL be high every cycle with A_wsp_FIR = 0,1,...,ile_wsp-1 (one per cycle); after the cycle with A_wsp_FIR=ile_wsp-1 it SHALL go to STORE.
REQ-019 In STORE, the block SHALL assert zapisz_wynik for 1 cycle and go to NEXT.
REQ-020 In NEXT, the block SHALL assert FSM_nowa_probka for 1 cycle and go to CHECK.
REQ-021 In CHECK, it SHALL sample licznik_full (valid one cycle after the NEXT pulse).
  - licznik_full=1: go to DONE.
  - Otherwise: go to CLR.
REQ-022 In DONE, done SHALL be high for 1 cycle, then the block returns to IDLE; blad holds until the next accepted start or rst.
REQ-023 Each output sample SHALL take ile_wsp+4 cycles (CLR+MAC+STORE+NEXT+CHECK); the block SHALL produce exactly ile_probek results.
REQ-024 start while busy=1 SHALL be ignored; latched counts SHALL NOT change mid-block.
REQ-025 stop=1 in any non-IDLE state SHALL force IDLE on the next edge.
  - No done pulse; all strobes low from that edge.
  - stop has priority over every other transition.
REQ-026 start and stop asserted together in IDLE: stop SHALL win and the block stays in IDLE.
REQ-027 All strobes (mac_clear, mac_en, zapisz_wynik, FSM_* controls, done) SHALL be registered outputs, decoded from state, and mutually exclusive except FSM_zapisz_probki with FSM_reset_licznik.
REQ-028 The tap counter SHALL be W_WSP bits and SHALL NOT wrap; its terminal compare is against latched ile_wsp-1.

Reset
REQ-029 rst=1 SHALL force IDLE with every output 0, A_wsp_FIR=0, latched counts=0, regardless of state; rst has priority over stop and start.

Structure
REQ-030 The state enum and the default W_WSP SHALL live in shared package fir_pkg.
REQ-031 The block SHALL be a single module with the tap counter inline; no sub-module.

Verification
REQ-032 Normal run: ile_probek=3, ile_wsp=4, start pulse, with a counter model attached.
  - Expect LOAD 1 cycle, then 3x8-cycle sample loops, then DONE.
  - Expect busy high for 26 cycles, 12 mac_en, 3 zapisz_wynik, 3 FSM_nowa_probka, 1 done, blad=0.
REQ-033 Zero parameters: ile_wsp=0 (and separately ile_probek=0).
  - Expect the LOAD pulse, then DONE, with blad=1.
  - Expect no mac_en and no FSM_nowa_probka.
REQ-034 Single sample and single tap: ile_probek=1, ile_wsp=1.
  - Expect the sequence CLR, MAC(A_wsp_FIR=0), STORE, NEXT, CHECK, with licznik_full=1 in CHECK, then DONE.
  - Expect exactly 1 result.
REQ-035 Stop mid-MAC: assert stop at A_wsp_FIR=2.
  - Expect IDLE on the next edge with busy=0 and all strobes 0.
  - Expect no done pulse.
REQ-036 Start during busy: pulse start at cycle 10 of a run.
  - Expect no relatch (cycle counts identical to the normal run) and a single done.
REQ-037 Reset mid-run: rst=1 in STORE; expect every output 0 on the next edge, and a following start runs normally.
